// File: rtl/reg_scoreboard_pkg.sv
// Shared types and defaults for the register scoreboard and its per-register counters.
package reg_scoreboard_pkg;
  localparam int REG_ADDR_W    = 5;
  localparam int NREG_DEFAULT  = 32;
  localparam int CNT_W_DEFAULT = 2;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/reg_scoreboard_sb_counter.sv
// One per-register pending-write counter: saturating up/down, clear wins over inc/dec.
module sb_counter
  import reg_scoreboard_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             nonzero,
  output logic             full
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // inc together with dec is a retire and a new writer on the same register: net zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = CNT_ZERO;
    end else if (inc && !dec && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else if (dec && !inc && (cnt_q != CNT_ZERO)) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt     = cnt_q;
  assign nonzero = |cnt_q;
  assign full    = &cnt_q;

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: counts in-flight writes per register between decode and writeback
// and stalls issue on RAW hazards or when a destination counter is already at its maximum.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int NREG  = NREG_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      issue_valid,
  input  logic      issue_rwrite,
  input  reg_addr_t issue_rd,
  input  logic      rs1_used,
  input  logic      rs2_used,
  input  reg_addr_t rs1_addr,
  input  reg_addr_t rs2_addr,
  input  logic      wb_valid,
  input  reg_addr_t wb_rd,
  input  logic      flush,
  output logic      stall,
  output logic      issue_accept,
  output logic      busy,
  output logic      wb_err
);

  localparam reg_addr_t X0 = '0;

  logic [NREG-1:0]            nonzero_vec;
  logic [NREG-1:0]            full_vec;
  logic [NREG-1:0][CNT_W-1:0] cnt_vec;

  logic do_inc;
  logic do_dec;
  logic spurious_wb;
  logic rs1_hit;
  logic rs2_hit;
  logic full_hit;
  logic wb_err_q;
  logic wb_err_d;

  // x0 is hard-wired to "nothing pending"; it has no counter.
  assign nonzero_vec[0] = 1'b0;
  assign full_vec[0]    = 1'b0;
  assign cnt_vec[0]     = '0;

  // Issue handshake: an instruction transfers when issue_valid & ~stall (issue_accept);
  // decode must hold the same instruction on its inputs while stall is high.
  assign do_dec      = wb_valid & (wb_rd != X0) & nonzero_vec[wb_rd];
  assign spurious_wb = wb_valid & (wb_rd != X0) & ~nonzero_vec[wb_rd];

  assign rs1_hit  = rs1_used & (rs1_addr != X0) & nonzero_vec[rs1_addr];
  assign rs2_hit  = rs2_used & (rs2_addr != X0) & nonzero_vec[rs2_addr];
  assign full_hit = issue_rwrite & (issue_rd != X0) & full_vec[issue_rd]
                  & ~(do_dec & (wb_rd == issue_rd));

  assign stall        = issue_valid & (rs1_hit | rs2_hit | full_hit);
  assign issue_accept = issue_valid & ~stall;
  assign do_inc       = issue_accept & issue_rwrite & (issue_rd != X0);

  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    sb_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc     (do_inc & (issue_rd == reg_addr_t'(r))),
      .dec     (do_dec & (wb_rd == reg_addr_t'(r))),
      .clr     (flush),
      .cnt     (cnt_vec[r]),
      .nonzero (nonzero_vec[r]),
      .full    (full_vec[r])
    );
  end

  assign busy = |cnt_vec;

  // Sticky until reset; flush deliberately leaves it alone.
  always_comb begin
    wb_err_d = wb_err_q | spurious_wb;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_err_q <= 1'b0;
    end else begin
      wb_err_q <= wb_err_d;
    end
  end

  assign wb_err = wb_err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios plus randomized traffic
// compared against a per-register pending-count model.
module tb_reg_scoreboard;
  localparam int NREG    = 32;
  localparam int CNT_MAX = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid;
  logic       issue_rwrite;
  logic [4:0] issue_rd;
  logic       rs1_used;
  logic       rs2_used;
  logic [4:0] rs1_addr;
  logic [4:0] rs2_addr;
  logic       wb_valid;
  logic [4:0] wb_rd;
  logic       flush;
  logic       stall;
  logic       issue_accept;
  logic       busy;
  logic       wb_err;

  int checks   = 0;
  int failures = 0;

  int m_cnt[NREG];
  bit m_err;

  reg_scoreboard dut (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .issue_rwrite (issue_rwrite),
    .issue_rd     (issue_rd),
    .rs1_used     (rs1_used),
    .rs2_used     (rs2_used),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .flush        (flush),
    .stall        (stall),
    .issue_accept (issue_accept),
    .busy         (busy),
    .wb_err       (wb_err)
  );

  // clock
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic bit model_stall();
    bit raw1, raw2, ovf, wb_frees;
    raw1     = rs1_used && rs1_addr != 0 && m_cnt[rs1_addr] != 0;
    raw2     = rs2_used && rs2_addr != 0 && m_cnt[rs2_addr] != 0;
    wb_frees = wb_valid && wb_rd == issue_rd && m_cnt[wb_rd] != 0;
    ovf      = issue_rwrite && issue_rd != 0 && m_cnt[issue_rd] == CNT_MAX && !wb_frees;
    return issue_valid && (raw1 || raw2 || ovf);
  endfunction

  function automatic bit model_busy();
    for (int r = 1; r < NREG; r++) if (m_cnt[r] != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_update(input bit st);
    bit inc, dec, bad;
    inc = issue_valid && !st && issue_rwrite && issue_rd != 0;
    dec = wb_valid && wb_rd != 0 && m_cnt[wb_rd] != 0;
    bad = wb_valid && wb_rd != 0 && m_cnt[wb_rd] == 0;
    if (rst) begin
      for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
      m_err = 1'b0;
    end else begin
      if (bad) m_err = 1'b1;
      if (flush) begin
        for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
      end else begin
        if (inc) m_cnt[issue_rd] = m_cnt[issue_rd] + 1;
        if (dec) m_cnt[wb_rd] = m_cnt[wb_rd] - 1;
      end
    end
  endtask

  // ---------------- drivers ----------------
  task automatic idle();
    rst = 1'b0; issue_valid = 1'b0; issue_rwrite = 1'b0; issue_rd = '0;
    rs1_used = 1'b0; rs2_used = 1'b0; rs1_addr = '0; rs2_addr = '0;
    wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;
  endtask

  task automatic drive_issue(input bit rw, input logic [4:0] rd, input bit u1,
                             input logic [4:0] a1, input bit u2, input logic [4:0] a2);
    issue_valid = 1'b1; issue_rwrite = rw; issue_rd = rd;
    rs1_used = u1; rs1_addr = a1; rs2_used = u2; rs2_addr = a2;
  endtask

  task automatic drive_wb(input logic [4:0] rd);
    wb_valid = 1'b1; wb_rd = rd;
  endtask

  // advance one clock; model follows the same inputs the DUT sampled
  task automatic step();
    bit st;
    st = model_stall();
    @(posedge clk);
    model_update(st);
    #1;
    idle();
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    drive_issue(1'b1, 5'd1, 1'b1, 5'd1, 1'b1, 5'd2);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (wb_err !== 1'b0) begin failures++; $display("FAIL reset_wb_err got=%b exp=0", wb_err); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++; if (issue_accept !== 1'b1) begin failures++; $display("FAIL reset_accept got=%b exp=1", issue_accept); end
    idle();
  endtask

  task automatic test_raw();
    do_reset();
    // rd=x5 also read by itself: no self stall
    drive_issue(1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 5'd0);
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL raw_self_stall got=%b exp=0", stall); end
    step();
    for (int c = 1; c <= 3; c++) begin
      drive_issue(1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 5'd0);
      if (c == 3) drive_wb(5'd5);
      #1;
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL raw_stall_c%0d got=%b exp=1", c, stall); end
      checks++; if (issue_accept !== 1'b0) begin failures++; $display("FAIL raw_accept_c%0d got=%b exp=0", c, issue_accept); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL raw_busy_c%0d got=%b exp=1", c, busy); end
      step();
    end
    drive_issue(1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 5'd0);
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL raw_release_stall got=%b exp=0", stall); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL raw_release_busy got=%b exp=0", busy); end
    idle();
  endtask

  task automatic test_x0();
    do_reset();
    drive_issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    step();
    drive_issue(1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0);
    drive_wb(5'd0);
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL x0_stall got=%b exp=0", stall); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL x0_busy got=%b exp=0", busy); end
    step();
    #1;
    checks++; if (wb_err !== 1'b0) begin failures++; $display("FAIL x0_wb_err got=%b exp=0", wb_err); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive_issue(1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0);
      #1;
      checks++; if (issue_accept !== 1'b1) begin failures++; $display("FAIL sat_fill%0d_accept got=%b exp=1", i, issue_accept); end
      step();
    end
    drive_issue(1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0);
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL sat_full_stall got=%b exp=1", stall); end
    checks++; if (issue_accept !== 1'b0) begin failures++; $display("FAIL sat_full_accept got=%b exp=0", issue_accept); end
    drive_wb(5'd7);
    #1;
    checks++; if (issue_accept !== 1'b1) begin failures++; $display("FAIL sat_wb_accept got=%b exp=1", issue_accept); end
    step();
    // count still at max: a further writer must stall again
    drive_issue(1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0);
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL sat_still_full got=%b exp=1", stall); end
    idle();
    for (int i = 0; i < 3; i++) begin
      drive_wb(5'd7);
      step();
    end
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL sat_drain_busy got=%b exp=0", busy); end
    checks++; if (wb_err !== 1'b0) begin failures++; $display("FAIL sat_drain_err got=%b exp=0", wb_err); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    drive_issue(1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0);
    step();
    drive_issue(1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0);
    drive_wb(5'd9);
    step();
    drive_issue(1'b1, 5'd10, 1'b0, 5'd0, 1'b1, 5'd9);
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL simul_same_stall got=%b exp=1", stall); end
    drive_issue(1'b1, 5'd10, 1'b0, 5'd0, 1'b0, 5'd0);
    step();
    drive_issue(1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0);
    drive_wb(5'd10);
    step();
    drive_issue(1'b0, 5'd0, 1'b1, 5'd10, 1'b0, 5'd0);
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL simul_x10_dec got=%b exp=0", stall); end
    // x9 now holds 2 writers
    drive_wb(5'd9);
    step();
    drive_issue(1'b0, 5'd0, 1'b1, 5'd9, 1'b0, 5'd0);
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL simul_x9_two got=%b exp=1", stall); end
    drive_wb(5'd9);
    step();
    drive_issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9);
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL simul_x9_zero got=%b exp=0", stall); end
    checks++; if (wb_err !== 1'b0) begin failures++; $display("FAIL simul_err got=%b exp=0", wb_err); end
    idle();
  endtask

  task automatic test_spurious();
    do_reset();
    drive_wb(5'd12);
    #1;
    checks++; if (wb_err !== 1'b0) begin failures++; $display("FAIL spur_same_cycle got=%b exp=0", wb_err); end
    step();
    #1;
    checks++; if (wb_err !== 1'b1) begin failures++; $display("FAIL spur_set got=%b exp=1", wb_err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL spur_busy got=%b exp=0", busy); end
    flush = 1'b1;
    step();
    #1;
    checks++; if (wb_err !== 1'b1) begin failures++; $display("FAIL spur_after_flush got=%b exp=1", wb_err); end
    rst = 1'b1;
    step();
    #1;
    checks++; if (wb_err !== 1'b0) begin failures++; $display("FAIL spur_after_rst got=%b exp=0", wb_err); end
  endtask

  task automatic test_flush_reset();
    do_reset();
    drive_issue(1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0);
    step();
    drive_issue(1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 5'd0);
    step();
    drive_issue(1'b1, 5'd6, 1'b1, 5'd3, 1'b0, 5'd0);
    flush = 1'b1;
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL flush_cycle_stall got=%b exp=1", stall); end
    drive_issue(1'b1, 5'd6, 1'b0, 5'd0, 1'b0, 5'd0);
    #1;
    checks++; if (issue_accept !== 1'b1) begin failures++; $display("FAIL flush_cycle_accept got=%b exp=1", issue_accept); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL flush_cycle_busy got=%b exp=1", busy); end
    step();
    drive_issue(1'b0, 5'd0, 1'b1, 5'd6, 1'b1, 5'd3);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b exp=0", busy); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL flush_stall got=%b exp=0", stall); end
    idle();
    // reset mid-stream, with competing issue/wb in the reset cycle
    drive_issue(1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0);
    drive_wb(5'd12);
    step();
    drive_issue(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0);
    drive_wb(5'd13);
    rst = 1'b1;
    step();
    drive_issue(1'b0, 5'd0, 1'b1, 5'd3, 1'b1, 5'd5);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (wb_err !== 1'b0) begin failures++; $display("FAIL rst_wb_err got=%b exp=0", wb_err); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", stall); end
    idle();
  endtask

  task automatic test_random();
    bit exp_stall;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      // small register window so hazards and saturation happen often
      issue_valid  = ($urandom_range(0, 3) != 0);
      issue_rwrite = ($urandom_range(0, 3) != 0);
      issue_rd     = 5'($urandom_range(0, 6));
      rs1_used     = $urandom_range(0, 1) == 1;
      rs2_used     = $urandom_range(0, 1) == 1;
      rs1_addr     = 5'($urandom_range(0, 6));
      rs2_addr     = 5'($urandom_range(0, 6));
      wb_valid     = ($urandom_range(0, 2) == 0);
      wb_rd        = 5'($urandom_range(0, 6));
      flush        = ($urandom_range(0, 99) == 0);
      rst          = ($urandom_range(0, 299) == 0);
      #1;
      exp_stall = model_stall();
      checks++; if (stall !== exp_stall) begin failures++; $display("FAIL rnd_stall n=%0d got=%b exp=%b", n, stall, exp_stall); end
      checks++; if (issue_accept !== (issue_valid && !exp_stall)) begin failures++; $display("FAIL rnd_accept n=%0d got=%b exp=%b", n, issue_accept, issue_valid && !exp_stall); end
      checks++; if (busy !== model_busy()) begin failures++; $display("FAIL rnd_busy n=%0d got=%b exp=%b", n, busy, model_busy()); end
      checks++; if (wb_err !== m_err) begin failures++; $display("FAIL rnd_wb_err n=%0d got=%b exp=%b", n, wb_err, m_err); end
      step();
    end
  endtask

  initial begin
    idle();
    for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
    m_err = 1'b0;
    test_reset();
    test_raw();
    test_x0();
    test_saturation();
    test_simultaneous();
    test_spurious();
    test_flush_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
